serial_lt_comparator: RTL



---
 rtl/serial_lt_comparator.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_lt_comparator.sv
// ============================================================================
// serial_lt_comparator: bit-serial LSB-first unsigned a<b / a<=b comparator.
// Optional feature macro: SERIAL_CMP_EQ_EN (adds the eq output).  Rev 1.0
// ============================================================================
`default_nettype none

module serial_lt_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             le_mode,
  output logic             busy,
  output logic             done,
  output logic             lt
`ifdef SERIAL_CMP_EQ_EN
  ,
  output logic             eq
`endif
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             chain;
  logic [CNT_W-1:0] cnt;

  logic diff;
  logic chain_nxt;
  logic accept;
  logic last;

  // Higher bits override lower ones: a differing bit forces the chain to b's bit.
  assign diff      = sa[0] ^ sb[0];
  assign chain_nxt = diff ? sb[0] : chain;
  assign accept    = start && (state != S_SHIFT);
  assign last      = (state == S_SHIFT) && (cnt == LAST_CNT);

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      chain <= 1'b0;
      cnt   <= '0;
      lt    <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      chain <= le_mode;
      cnt   <= '0;
    end else if (state == S_SHIFT) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      chain <= chain_nxt;
      cnt   <= cnt + 1'b1;
      if (last) lt <= chain_nxt;
    end
  end

`ifdef SERIAL_CMP_EQ_EN
  logic eq_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      eq_acc <= 1'b0;
      eq     <= 1'b0;
    end else if (accept) begin
      eq_acc <= 1'b1;
    end else if (state == S_SHIFT) begin
      eq_acc <= eq_acc & ~diff;
      if (last) eq <= eq_acc & ~diff;
    end
  end
`endif

endmodule

`default_nettype wire
